// File: rtl/usb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : usb_pkg                                                |
// | Description : Shared packet type, PID codes and FSM state encoding   |
// |               for the host-side USB transaction engine.              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package usb_pkg;

  // Widest payload a packet can carry; the engine's DATA_W must not exceed it.
  localparam int USB_MAX_DATA_W = 64;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  typedef struct packed {
    logic [3:0]                pid;
    logic [6:0]                addr;
    logic [3:0]                endp;
    logic [USB_MAX_DATA_W-1:0] data;
  } pkt_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_IN_TOK   = 3'd1,
    ST_IN_RX    = 3'd2,
    ST_IN_HS    = 3'd3,
    ST_OUT_TOK  = 3'd4,
    ST_OUT_DATA = 3'd5,
    ST_OUT_RX   = 3'd6
  } state_e;

  // DATA PID that matches a given data toggle value.
  function automatic logic [3:0] data_pid(input logic tog);
    return tog ? PID_DATA1 : PID_DATA0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/usb_txn_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : usb_txn_timer                                          |
// | Description : Receive-wait timer plus saturating timeout and corrupt |
// |               counters. The *_last outputs flag that one more        |
// |               increment reaches the configured limit.                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module usb_txn_timer #(
  parameter int TIMEOUT_CYC  = 256,
  parameter int MAX_TIMEOUTS = 8,
  parameter int MAX_CORRUPT  = 8
) (
  input  logic clk,
  input  logic rst_b,
  input  logic cnt_clr_i,
  input  logic timer_clr_i,
  input  logic timer_inc_i,
  input  logic to_inc_i,
  input  logic cr_inc_i,
  output logic timeout_o,
  output logic to_last_o,
  output logic cr_last_o
);

  localparam int TIMER_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TIMER_W-1:0] timer_q;
  logic [3:0]         to_cnt_q;
  logic [3:0]         cr_cnt_q;

  assign timeout_o = (timer_q == TIMER_W'(TIMEOUT_CYC - 1));
  assign to_last_o = (to_cnt_q >= 4'(MAX_TIMEOUTS - 1));
  assign cr_last_o = (cr_cnt_q >= 4'(MAX_CORRUPT - 1));

  // Timer counts idle receive cycles and parks at the timeout value.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      timer_q <= '0;
    end else if (cnt_clr_i || timer_clr_i) begin
      timer_q <= '0;
    end else if (timer_inc_i && !timeout_o) begin
      timer_q <= timer_q + 1'b1;
    end
  end

  // Retry counters saturate at their limits and clear between transactions.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      to_cnt_q <= '0;
      cr_cnt_q <= '0;
    end else if (cnt_clr_i) begin
      to_cnt_q <= '0;
      cr_cnt_q <= '0;
    end else begin
      if (to_inc_i && (to_cnt_q < 4'(MAX_TIMEOUTS))) to_cnt_q <= to_cnt_q + 1'b1;
      if (cr_inc_i && (cr_cnt_q < 4'(MAX_CORRUPT)))  cr_cnt_q <= cr_cnt_q + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/usb_host_txn_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : usb_host_txn_engine                                    |
// | Description : Host-side USB IN/OUT transaction sequencer with data   |
// |               toggle tracking, timeout/corrupt retry limits and NAK  |
// |               handling. Define USB_STALL_EN to end transactions on a |
// |               device STALL and expose the sticky 'stalled' output.   |
// |               DATA_W must not exceed usb_pkg::USB_MAX_DATA_W.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module usb_host_txn_engine
  import usb_pkg::*;
#(
  parameter int DATA_W       = 64,
  parameter int TIMEOUT_CYC  = 256,
  parameter int MAX_TIMEOUTS = 8,
  parameter int MAX_CORRUPT  = 8
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              in_trans,
  input  logic              out_trans,
  input  logic              toggle_clr,
  input  logic [6:0]        dev_addr,
  input  logic [3:0]        dev_endp,
  input  logic [DATA_W-1:0] data_from_host,
  input  logic              pkt_sent,
  input  logic              pkt_received,
  input  logic              crc_correct,
  input  pkt_t              pkt_in,
  output pkt_t              pkt_out,
  output logic              encode,
  output logic              kill,
  output logic              decode,
  output logic [DATA_W-1:0] data_to_host,
  output logic              busy,
`ifdef USB_STALL_EN
  output logic              stalled,
`endif
  output logic              success,
  output logic              failure
);

  state_e            state_q, state_d;
  pkt_t              pkt_out_q, pkt_out_d;
  logic              encode_q, encode_d;
  logic              kill_q, kill_d;
  logic              decode_q, decode_d;
  logic              success_q, success_d;
  logic              failure_q, failure_d;
  logic [DATA_W-1:0] data_to_host_q, data_to_host_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [6:0]        addr_q, addr_d;
  logic [3:0]        endp_q, endp_d;
  logic              in_tog_q, in_tog_d;
  logic              out_tog_q, out_tog_d;
  logic              done_q, done_d;
  logic              reissue_q, reissue_d;
`ifdef USB_STALL_EN
  logic              stalled_q, stalled_d;
`endif

  logic w_cnt_clr, w_timer_clr, w_timer_inc, w_to_inc, w_cr_inc;
  logic w_timeout, w_to_last, w_cr_last;
  logic w_rx_bad, w_rx_good, w_is_data;
  logic w_unused_pkt_fields;

  assign w_rx_bad  = pkt_received && !crc_correct;
  assign w_rx_good = pkt_received && crc_correct;
  assign w_is_data = (pkt_in.pid == PID_DATA0) || (pkt_in.pid == PID_DATA1);
  // Device address/endpoint fields of received packets carry no meaning for the host.
  assign w_unused_pkt_fields = ^{pkt_in.addr, pkt_in.endp};

  function automatic pkt_t mk_pkt(input logic [3:0] pid, input logic [6:0] a,
                                  input logic [3:0] e, input logic [DATA_W-1:0] d);
    pkt_t p;
    p.pid  = pid;
    p.addr = a;
    p.endp = e;
    p.data = USB_MAX_DATA_W'(d);
    return p;
  endfunction

  usb_txn_timer #(
    .TIMEOUT_CYC  (TIMEOUT_CYC),
    .MAX_TIMEOUTS (MAX_TIMEOUTS),
    .MAX_CORRUPT  (MAX_CORRUPT)
  ) u_timer (
    .clk         (clk),
    .rst_b       (rst_b),
    .cnt_clr_i   (w_cnt_clr),
    .timer_clr_i (w_timer_clr),
    .timer_inc_i (w_timer_inc),
    .to_inc_i    (w_to_inc),
    .cr_inc_i    (w_cr_inc),
    .timeout_o   (w_timeout),
    .to_last_o   (w_to_last),
    .cr_last_o   (w_cr_last)
  );

  // Register every piece of transaction state; reset abandons any transfer silently.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q        <= ST_IDLE;
      pkt_out_q      <= '0;
      encode_q       <= 1'b0;
      kill_q         <= 1'b0;
      decode_q       <= 1'b0;
      success_q      <= 1'b0;
      failure_q      <= 1'b0;
      data_to_host_q <= '0;
      data_q         <= '0;
      addr_q         <= '0;
      endp_q         <= '0;
      in_tog_q       <= 1'b0;
      out_tog_q      <= 1'b0;
      done_q         <= 1'b0;
      reissue_q      <= 1'b0;
`ifdef USB_STALL_EN
      stalled_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      pkt_out_q      <= pkt_out_d;
      encode_q       <= encode_d;
      kill_q         <= kill_d;
      decode_q       <= decode_d;
      success_q      <= success_d;
      failure_q      <= failure_d;
      data_to_host_q <= data_to_host_d;
      data_q         <= data_d;
      addr_q         <= addr_d;
      endp_q         <= endp_d;
      in_tog_q       <= in_tog_d;
      out_tog_q      <= out_tog_d;
      done_q         <= done_d;
      reissue_q      <= reissue_d;
`ifdef USB_STALL_EN
      stalled_q      <= stalled_d;
`endif
    end
  end

  // Next-state and output decode; every packet load is paired with an encode/kill pulse.
  always_comb begin
    state_d        = state_q;
    pkt_out_d      = pkt_out_q;
    encode_d       = 1'b0;
    kill_d         = 1'b0;
    decode_d       = 1'b0;
    success_d      = 1'b0;
    failure_d      = 1'b0;
    data_to_host_d = data_to_host_q;
    data_d         = data_q;
    addr_d         = addr_q;
    endp_d         = endp_q;
    in_tog_d       = in_tog_q;
    out_tog_d      = out_tog_q;
    done_d         = done_q;
    reissue_d      = reissue_q;
`ifdef USB_STALL_EN
    stalled_d      = stalled_q;
`endif
    w_cnt_clr      = 1'b0;
    w_timer_clr    = 1'b0;
    w_timer_inc    = 1'b0;
    w_to_inc       = 1'b0;
    w_cr_inc       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        w_cnt_clr = 1'b1;
        if (toggle_clr) begin
          in_tog_d  = 1'b0;
          out_tog_d = 1'b0;
`ifdef USB_STALL_EN
          stalled_d = 1'b0;
`endif
        end
        if (in_trans || out_trans) begin
          addr_d    = dev_addr;
          endp_d    = dev_endp;
          data_d    = data_from_host;
          done_d    = 1'b0;
          reissue_d = 1'b0;
          pkt_out_d = mk_pkt(in_trans ? PID_IN : PID_OUT, dev_addr, dev_endp, '0);
          encode_d  = 1'b1;
          kill_d    = 1'b1;
          state_d   = in_trans ? ST_IN_TOK : ST_OUT_TOK;
        end
      end

      ST_IN_TOK: begin
        if (pkt_sent) begin
          decode_d    = 1'b1;
          w_timer_clr = 1'b1;
          state_d     = ST_IN_RX;
        end
      end

      ST_IN_RX: begin
        if (w_rx_bad) begin
          w_cr_inc = 1'b1;
          if (w_cr_last) begin
            failure_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            pkt_out_d = mk_pkt(PID_NAK, addr_q, endp_q, '0);
            encode_d  = 1'b1;
            kill_d    = 1'b1;
            done_d    = 1'b0;
            reissue_d = 1'b0;
            state_d   = ST_IN_HS;
          end
        end else if (w_rx_good && w_is_data) begin
          // A stale toggle means our previous ACK was lost: ACK again, keep the old data.
          if (pkt_in.pid == data_pid(in_tog_q)) begin
            data_to_host_d = DATA_W'(pkt_in.data);
            in_tog_d       = ~in_tog_q;
            done_d         = 1'b1;
            reissue_d      = 1'b0;
          end else begin
            done_d         = 1'b0;
            reissue_d      = 1'b1;
          end
          pkt_out_d = mk_pkt(PID_ACK, addr_q, endp_q, '0);
          encode_d  = 1'b1;
          kill_d    = 1'b1;
          state_d   = ST_IN_HS;
        end else if (w_rx_good && (pkt_in.pid == PID_NAK)) begin
          pkt_out_d = mk_pkt(PID_IN, addr_q, endp_q, '0);
          encode_d  = 1'b1;
          kill_d    = 1'b1;
          state_d   = ST_IN_TOK;
`ifdef USB_STALL_EN
        end else if (w_rx_good && (pkt_in.pid == PID_STALL)) begin
          stalled_d = 1'b1;
          failure_d = 1'b1;
          state_d   = ST_IDLE;
`endif
        end else if (w_timeout) begin
          w_to_inc = 1'b1;
          if (w_to_last) begin
            failure_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            pkt_out_d = mk_pkt(PID_IN, addr_q, endp_q, '0);
            encode_d  = 1'b1;
            kill_d    = 1'b1;
            state_d   = ST_IN_TOK;
          end
        end else begin
          w_timer_inc = 1'b1;
        end
      end

      ST_IN_HS: begin
        if (pkt_sent) begin
          if (done_q) begin
            success_d = 1'b1;
            state_d   = ST_IDLE;
          end else if (reissue_q) begin
            pkt_out_d = mk_pkt(PID_IN, addr_q, endp_q, '0);
            encode_d  = 1'b1;
            kill_d    = 1'b1;
            state_d   = ST_IN_TOK;
          end else begin
            decode_d    = 1'b1;
            w_timer_clr = 1'b1;
            state_d     = ST_IN_RX;
          end
        end
      end

      ST_OUT_TOK: begin
        if (pkt_sent) begin
          pkt_out_d = mk_pkt(data_pid(out_tog_q), addr_q, endp_q, data_q);
          encode_d  = 1'b1;
          kill_d    = 1'b1;
          state_d   = ST_OUT_DATA;
        end
      end

      ST_OUT_DATA: begin
        if (pkt_sent) begin
          decode_d    = 1'b1;
          w_timer_clr = 1'b1;
          state_d     = ST_OUT_RX;
        end
      end

      ST_OUT_RX: begin
        if (w_rx_bad || (w_rx_good && (pkt_in.pid == PID_NAK))) begin
          w_cr_inc = 1'b1;
          if (w_cr_last) begin
            failure_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            pkt_out_d = mk_pkt(data_pid(out_tog_q), addr_q, endp_q, data_q);
            encode_d  = 1'b1;
            kill_d    = 1'b1;
            state_d   = ST_OUT_DATA;
          end
        end else if (w_rx_good && (pkt_in.pid == PID_ACK)) begin
          out_tog_d = ~out_tog_q;
          success_d = 1'b1;
          state_d   = ST_IDLE;
`ifdef USB_STALL_EN
        end else if (w_rx_good && (pkt_in.pid == PID_STALL)) begin
          stalled_d = 1'b1;
          failure_d = 1'b1;
          state_d   = ST_IDLE;
`endif
        end else if (w_timeout) begin
          w_to_inc = 1'b1;
          if (w_to_last) begin
            failure_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            pkt_out_d = mk_pkt(data_pid(out_tog_q), addr_q, endp_q, data_q);
            encode_d  = 1'b1;
            kill_d    = 1'b1;
            state_d   = ST_OUT_DATA;
          end
        end else begin
          w_timer_inc = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign pkt_out      = pkt_out_q;
  assign encode       = encode_q;
  assign kill         = kill_q;
  assign decode       = decode_q;
  assign success      = success_q;
  assign failure      = failure_q;
  assign data_to_host = data_to_host_q;
  assign busy         = (state_q != ST_IDLE);
`ifdef USB_STALL_EN
  assign stalled      = stalled_q;
`endif

endmodule
`default_nettype wire
